// File: rtl/adc_read_ad7476_pkg.sv
// Shared types and frame geometry for the AD7476-class serial ADC reader.
package adc_read_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CS_SETUP,
      SCLK_LO,
      SCLK_HI,
      QUIET
   } state_t;

   localparam int unsigned FRAME_BITS = 16;
   localparam int unsigned LEAD_BITS  = 4;
   localparam int unsigned DATA_BITS  = 12;

endpackage

// File: rtl/adc_read_ad7476_tick_gen.sv
// Clock divider: one-clock tick pulse every DIVIDE clocks, restartable via clear.
module tick_gen #(
   parameter int unsigned DIVIDE = 10
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic tick
);

   localparam int unsigned CW = (DIVIDE > 2) ? $clog2(DIVIDE) : 2;

   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;

   assign tick = (count_q == CW'(DIVIDE - 1));

   // Next count: held at zero while cleared, wraps on the tick clock.
   always_comb begin
      count_d = count_q + 1'b1;
      if (clear || tick) begin
         count_d = '0;
      end
   end

   // Counter register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/adc_read_ad7476.sv
// AD7476-class serial ADC reader: frames cs/sclk, shifts in 16 bits, publishes 12.
module adc_read_ad7476
   import adc_read_pkg::*;
#(
   parameter int unsigned DELAY_FACTOR = 10,
   parameter int unsigned QUIET_TICKS  = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   output logic                 busy,
   output logic [DATA_BITS-1:0] data,
   output logic                 valid,
   output logic                 err,
   output logic                 cs,
   output logic                 sclk,
   input  logic                 sdata
);

   localparam int unsigned BW = $clog2(FRAME_BITS);
   localparam int unsigned QW = $clog2(QUIET_TICKS + 1);

   state_t                  state_q, state_d;
   logic                    busy_q, busy_d;
   logic                    valid_q, valid_d;
   logic                    err_q, err_d;
   logic                    cs_q, cs_d;
   logic                    sclk_q, sclk_d;
   logic                    sync1_q, sync1_d;
   logic                    sync2_q, sync2_d;
   logic [DATA_BITS-1:0]    data_q, data_d;
   logic [FRAME_BITS-1:0]   shift_q, shift_d;
   logic [BW-1:0]           bit_cnt_q, bit_cnt_d;
   logic [QW-1:0]           quiet_cnt_q, quiet_cnt_d;
   logic                    tick;

   // The divider only runs during a conversion so tick n lands n*DELAY_FACTOR clocks after accept.
   tick_gen #(
      .DIVIDE (DELAY_FACTOR)
   ) u_tick_gen (
      .clk   (clk),
      .rst   (rst),
      .clear (!busy_q),
      .tick  (tick)
   );

   // Next-state logic: accept, synchronizer, and tick-paced frame sequencing.
   always_comb begin
      state_d     = state_q;
      busy_d      = busy_q;
      valid_d     = 1'b0;
      err_d       = err_q;
      cs_d        = cs_q;
      sclk_d      = sclk_q;
      data_d      = data_q;
      shift_d     = shift_q;
      bit_cnt_d   = bit_cnt_q;
      quiet_cnt_d = quiet_cnt_q;
      sync1_d     = sdata;
      sync2_d     = sync1_q;

      if (!busy_q && start) begin
         busy_d = 1'b1;
      end

      if (tick) begin
         case (state_q)
            IDLE: begin
               if (busy_q) begin
                  cs_d      = 1'b0;
                  bit_cnt_d = BW'(FRAME_BITS - 1);
                  state_d   = CS_SETUP;
               end
            end
            CS_SETUP: begin
               sclk_d  = 1'b0;
               state_d = SCLK_LO;
            end
            SCLK_LO: begin
               shift_d = {shift_q[FRAME_BITS-2:0], sync2_q};
               sclk_d  = 1'b1;
               state_d = SCLK_HI;
            end
            SCLK_HI: begin
               if (bit_cnt_q != '0) begin
                  bit_cnt_d = bit_cnt_q - 1'b1;
                  sclk_d    = 1'b0;
                  state_d   = SCLK_LO;
               end else begin
                  cs_d        = 1'b1;
                  quiet_cnt_d = '0;
                  state_d     = QUIET;
               end
            end
            QUIET: begin
               if (quiet_cnt_q == QW'(QUIET_TICKS - 1)) begin
                  data_d  = shift_q[DATA_BITS-1:0];
                  err_d   = |shift_q[FRAME_BITS-1 -: LEAD_BITS];
                  valid_d = 1'b1;
                  busy_d  = 1'b0;
                  state_d = IDLE;
               end else begin
                  quiet_cnt_d = quiet_cnt_q + 1'b1;
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // State and output registers; reset aborts any frame and parks the bus idle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         busy_q      <= 1'b0;
         valid_q     <= 1'b0;
         err_q       <= 1'b0;
         cs_q        <= 1'b1;
         sclk_q      <= 1'b1;
         sync1_q     <= 1'b0;
         sync2_q     <= 1'b0;
         data_q      <= '0;
         shift_q     <= '0;
         bit_cnt_q   <= BW'(FRAME_BITS - 1);
         quiet_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         busy_q      <= busy_d;
         valid_q     <= valid_d;
         err_q       <= err_d;
         cs_q        <= cs_d;
         sclk_q      <= sclk_d;
         sync1_q     <= sync1_d;
         sync2_q     <= sync2_d;
         data_q      <= data_d;
         shift_q     <= shift_d;
         bit_cnt_q   <= bit_cnt_d;
         quiet_cnt_q <= quiet_cnt_d;
      end
   end

   assign busy  = busy_q;
   assign data  = data_q;
   assign valid = valid_q;
   assign err   = err_q;
   assign cs    = cs_q;
   assign sclk  = sclk_q;

endmodule

// File: tb/tb_adc_read_ad7476.sv
// Directed bench for adc_read_ad7476 with a behavioural AD7476 serial model.
module tb_adc_read_ad7476;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        busy;
   logic [11:0] data;
   logic        valid;
   logic        err;
   logic        cs;
   logic        sclk;
   logic        sdata = 1'b0;

   logic [15:0] model_frame;
   logic [3:0]  model_idx = 4'd0;

   int cyc = 0;
   int falls = 0;
   int valid_count = 0;
   int last_valid_cyc = 0;
   logic [11:0] last_data = '0;
   logic        last_err = 1'b0;
   int busy_fall_cyc = 0;
   int cs_rise_cyc = 0;
   int cs_fall_cyc = 0;
   logic prev_busy = 1'b0;
   logic prev_cs = 1'b1;

   int errors = 0;
   int checks = 0;

   adc_read_ad7476 #(
      .DELAY_FACTOR (10),
      .QUIET_TICKS  (2)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .busy  (busy),
      .data  (data),
      .valid (valid),
      .err   (err),
      .cs    (cs),
      .sclk  (sclk),
      .sdata (sdata)
   );

   // 100 MHz clock.
   always #5 clk = ~clk;

   // Count active clock edges so event times can be expressed relative to accept.
   always @(posedge clk) cyc <= cyc + 1;

   // ADC model: launches frame bits MSB first on each falling sclk while selected.
   always @(negedge sclk or posedge cs) begin
      if (cs) begin
         model_idx = 4'd0;
      end else begin
         sdata = model_frame[4'd15 - model_idx];
         model_idx = model_idx + 4'd1;
      end
   end

   // Count falling sclk edges seen while the ADC is selected.
   always @(negedge sclk) begin
      if (cs === 1'b0) falls <= falls + 1;
   end

   // Record valid pulses and edge times of busy and cs.
   always @(negedge clk) begin
      prev_busy <= busy;
      prev_cs   <= cs;
      if (valid === 1'b1) begin
         valid_count    <= valid_count + 1;
         last_valid_cyc <= cyc;
         last_data      <= data;
         last_err       <= err;
      end
      if (prev_busy && !busy) busy_fall_cyc <= cyc;
      if (!prev_cs && cs) cs_rise_cyc <= cyc;
      if (prev_cs && !cs) cs_fall_cyc <= cyc;
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
      end
   endtask

   task automatic stepClock();
      @(negedge clk);
      #1;
   endtask

   // Pulse start for one clock with the ADC model loaded; returns the accepting edge.
   task automatic applyStimulus(input logic [15:0] frame, output int accept_edge);
      model_frame = frame;
      start = 1'b1;
      accept_edge = cyc + 1;
      stepClock();
      start = 1'b0;
   endtask

   task automatic waitValid(input int base_count, input int limit);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < limit; i++) begin
         if (valid_count > base_count) begin
            ok = 1'b1;
            break;
         end
         stepClock();
      end
      checkOutput("valid_seen", 32'(ok), 32'd1);
   endtask

   initial begin
      int acc;
      int v0;
      int f0;
      int v1;
      int rise1;

      rst = 1'b1;
      start = 1'b0;
      model_frame = 16'h0000;
      #1;
      checkOutput("rst_cs", 32'(cs), 32'd1);
      checkOutput("rst_sclk", 32'(sclk), 32'd1);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_valid", 32'(valid), 32'd0);
      checkOutput("rst_data", 32'(data), 32'h000);
      checkOutput("rst_err", 32'(err), 32'd0);
      repeat (3) stepClock();
      rst = 1'b0;
      f0 = falls;
      repeat (50) stepClock();
      checkOutput("idle_no_sclk", 32'(falls - f0), 32'd0);
      checkOutput("idle_cs", 32'(cs), 32'd1);

      $display("[TB] single conversion 0x0ABC");
      v0 = valid_count;
      f0 = falls;
      applyStimulus(16'h0ABC, acc);
      waitValid(v0, 500);
      checkOutput("single_latency", 32'(last_valid_cyc - acc), 32'd360);
      checkOutput("single_data", 32'(last_data), 32'hABC);
      checkOutput("single_err", 32'(last_err), 32'd0);
      checkOutput("single_falls", 32'(falls - f0), 32'd16);
      checkOutput("single_cs_fall", 32'(cs_fall_cyc - acc), 32'd10);
      checkOutput("single_cs_rise", 32'(cs_rise_cyc - acc), 32'd340);
      checkOutput("single_busy", 32'(busy), 32'd0);
      stepClock();
      checkOutput("single_pulse_width", 32'(valid), 32'd0);

      $display("[TB] leading-bit error 0x8123");
      v0 = valid_count;
      applyStimulus(16'h8123, acc);
      waitValid(v0, 500);
      checkOutput("lead_data", 32'(last_data), 32'h123);
      checkOutput("lead_err", 32'(last_err), 32'd1);
      checkOutput("lead_count", 32'(valid_count - v0), 32'd1);

      $display("[TB] start while busy");
      v0 = valid_count;
      applyStimulus(16'h0555, acc);
      repeat (49) stepClock();
      start = 1'b1;
      stepClock();
      start = 1'b0;
      repeat (149) stepClock();
      start = 1'b1;
      stepClock();
      start = 1'b0;
      waitValid(v0, 500);
      checkOutput("busy_fall", 32'(busy_fall_cyc - acc), 32'd360);
      checkOutput("busy_data", 32'(last_data), 32'h555);
      repeat (400) stepClock();
      checkOutput("busy_one_frame", 32'(valid_count - v0), 32'd1);
      checkOutput("busy_idle_after", 32'(busy), 32'd0);

      $display("[TB] back-to-back 0x0FFF then 0x0001");
      v0 = valid_count;
      model_frame = 16'h0FFF;
      start = 1'b1;
      acc = cyc + 1;
      waitValid(v0, 500);
      v1 = last_valid_cyc;
      rise1 = cs_rise_cyc;
      checkOutput("b2b_latency", 32'(v1 - acc), 32'd360);
      checkOutput("b2b_data1", 32'(last_data), 32'hFFF);
      model_frame = 16'h0001;
      stepClock();
      checkOutput("b2b_reaccept", 32'(busy), 32'd1);
      start = 1'b0;
      waitValid(v0 + 1, 500);
      checkOutput("b2b_spacing", 32'(last_valid_cyc - v1), 32'd361);
      checkOutput("b2b_data2", 32'(last_data), 32'h001);
      checkOutput("b2b_cs_gap", 32'(cs_fall_cyc - rise1), 32'd31);

      $display("[TB] mid-frame reset");
      stepClock();
      v0 = valid_count;
      applyStimulus(16'h0ABC, acc);
      repeat (200) stepClock();
      checkOutput("mid_cs_low", 32'(cs), 32'd0);
      checkOutput("mid_sclk_low", 32'(sclk), 32'd0);
      rst = 1'b1;
      #1;
      checkOutput("mid_rst_cs", 32'(cs), 32'd1);
      checkOutput("mid_rst_sclk", 32'(sclk), 32'd1);
      checkOutput("mid_rst_busy", 32'(busy), 32'd0);
      repeat (3) stepClock();
      rst = 1'b0;
      repeat (400) stepClock();
      checkOutput("mid_no_valid", 32'(valid_count - v0), 32'd0);
      checkOutput("mid_data_kept", 32'(data), 32'h000);
      checkOutput("mid_err_kept", 32'(err), 32'd0);

      v0 = valid_count;
      applyStimulus(16'h0321, acc);
      waitValid(v0, 500);
      checkOutput("post_latency", 32'(last_valid_cyc - acc), 32'd360);
      checkOutput("post_data", 32'(last_data), 32'h321);
      checkOutput("post_err", 32'(last_err), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
